// File: rtl/elev_pkg.sv
// Shared types for the N-floor elevator controller: direction encoding, FSM states, one-hot check.
// Build option: ELEV_ESTOP_EN adds the ESTOP state (and the estop port on elevator_ctrl_n).
package elev_pkg;

    localparam int MAX_FLOORS = 16;

    typedef enum logic [1:0] {
        DIR_STOP = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_t;

`ifdef ELEV_ESTOP_EN
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MOVE_UP   = 3'd1,
        S_MOVE_DOWN = 3'd2,
        S_DOOR_OPEN = 3'd3,
        S_ESTOP     = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MOVE_UP   = 3'd1,
        S_MOVE_DOWN = 3'd2,
        S_DOOR_OPEN = 3'd3
    } state_t;
`endif

    // True when exactly one bit is set; callers zero-extend narrower vectors.
    function automatic logic onehot_valid(input logic [MAX_FLOORS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/elev_req_bank.sv
// Pending-request register (set/clear, clear wins) plus the above/below/here reductions
// relative to the car's current floor.
module elev_req_bank #(
    parameter int N_FLOORS = 3,
    parameter int FW       = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_FLOORS-1:0] set,
    input  logic [N_FLOORS-1:0] clr,
    input  logic [FW-1:0]       cur,
    output logic [N_FLOORS-1:0] pending,
    output logic                above,
    output logic                below,
    output logic                here
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            pending <= (pending | set) & ~clr;
        end
    end

    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (i > int'(cur)) begin
                above = above | pending[i];
            end
            if (i < int'(cur)) begin
                below = below | pending[i];
            end
        end
        here = pending[cur];
    end

endmodule

// File: rtl/elevator_ctrl_n.sv
// N-floor SCAN elevator controller: request latching, travel FSM, door timer, idle logout.
// Build option: ELEV_ESTOP_EN adds the estop input and an ESTOP state released by admin.
module elevator_ctrl_n
    import elev_pkg::*;
#(
    parameter int  N_FLOORS    = 3,
    parameter int  DOOR_CYCLES = 8,
    parameter int  IDLE_LOGOUT = 64,
    localparam int FW          = (N_FLOORS > 2) ? $clog2(N_FLOORS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                movement,
    input  logic                admin,
`ifdef ELEV_ESTOP_EN
    input  logic                estop,
`endif
    input  logic [N_FLOORS-1:0] reqin,
    input  logic [N_FLOORS-1:0] reqout,
    input  logic [N_FLOORS-1:0] pres,
    output logic [1:0]          dir,
    output logic [N_FLOORS-1:0] door,
    output logic                logout,
    output logic [FW-1:0]       cur_floor,
    output logic [N_FLOORS-1:0] pending,
    output logic                pres_err,
    output state_t              state_dbg
);

    localparam int DW = $clog2(DOOR_CYCLES + 1);
    localparam int IW = $clog2(IDLE_LOGOUT + 1);
    localparam logic [N_FLOORS-1:0] FLOOR0 = N_FLOORS'(1);

    state_t                state, state_n;
    dir_t                  last_dir, dir_q;
    logic [FW-1:0]         pres_idx;
    logic                  pres_valid, pres_hit;
    logic [N_FLOORS-1:0]   new_req, bank_set, bank_clr, cur_onehot;
    logic                  above, below, here;
    logic [DW-1:0]         door_tmr;
    logic                  door_last, door_reload;
    logic [IW-1:0]         idle_cnt;
    logic                  idle_run;
    logic                  estop_now, estop_exit, estop_hold;

`ifdef ELEV_ESTOP_EN
    assign estop_now  = estop;
    assign estop_exit = !estop && admin;
    assign estop_hold = (state == S_ESTOP);
`else
    logic unused_admin;
    assign unused_admin = admin;
    assign estop_now    = 1'b0;
    assign estop_exit   = 1'b0;
    assign estop_hold   = 1'b0;
`endif

    // Car buttons only count while the login block grants movement.
    assign new_req    = reqout | (reqin & {N_FLOORS{movement}});
    assign cur_onehot = FLOOR0 << cur_floor;
    assign bank_set   = estop_hold ? '0 : new_req;
    assign bank_clr   = (state == S_DOOR_OPEN) ? cur_onehot : '0;

    elev_req_bank #(
        .N_FLOORS (N_FLOORS),
        .FW       (FW)
    ) u_req_bank (
        .clk     (clk),
        .rst     (rst),
        .set     (bank_set),
        .clr     (bank_clr),
        .cur     (cur_floor),
        .pending (pending),
        .above   (above),
        .below   (below),
        .here    (here)
    );

    assign pres_valid = onehot_valid(MAX_FLOORS'(pres));
    assign pres_hit   = pres_valid && ((pending & pres) != '0);

    always_comb begin
        pres_idx = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (pres[i]) begin
                pres_idx = FW'(i);
            end
        end
    end

    // A press at the open floor is cleared by the bank but still restarts the door timer.
    assign door_reload = (new_req & cur_onehot) != '0;
    assign door_last   = (door_tmr == DW'(DOOR_CYCLES - 1));
    assign idle_run    = (state == S_IDLE) && movement && (pending == '0) && (new_req == '0);

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (here) begin
                    state_n = S_DOOR_OPEN;
                end else if (above && below) begin
                    state_n = (last_dir == DIR_DOWN) ? S_MOVE_DOWN : S_MOVE_UP;
                end else if (above) begin
                    state_n = S_MOVE_UP;
                end else if (below) begin
                    state_n = S_MOVE_DOWN;
                end
            end
            S_MOVE_UP: begin
                if (pres_valid && (pres_hit || pres[N_FLOORS-1])) begin
                    state_n = S_DOOR_OPEN;
                end
            end
            S_MOVE_DOWN: begin
                if (pres_valid && (pres_hit || pres[0])) begin
                    state_n = S_DOOR_OPEN;
                end
            end
            S_DOOR_OPEN: begin
                if (door_last && !door_reload) begin
                    if (last_dir == DIR_DOWN) begin
                        if (below) begin
                            state_n = S_MOVE_DOWN;
                        end else if (above) begin
                            state_n = S_MOVE_UP;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        if (above) begin
                            state_n = S_MOVE_UP;
                        end else if (below) begin
                            state_n = S_MOVE_DOWN;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end
                end
            end
`ifdef ELEV_ESTOP_EN
            S_ESTOP: begin
                if (estop_exit) begin
                    state_n = S_IDLE;
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase
        if (estop_now) begin
            state_n = S_ESTOP_OR_IDLE();
        end
    end

    // Without the estop build estop_now is tied low, so this never fires there.
    function automatic state_t S_ESTOP_OR_IDLE();
`ifdef ELEV_ESTOP_EN
        return S_ESTOP;
`else
        return S_IDLE;
`endif
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            last_dir  <= DIR_UP;
            cur_floor <= '0;
            door_tmr  <= '0;
            idle_cnt  <= '0;
            logout    <= 1'b0;
            pres_err  <= 1'b0;
        end else begin
            state    <= state_n;
            pres_err <= (pres != '0) && !pres_valid;
            if (pres_valid) begin
                cur_floor <= pres_idx;
            end
            if (state_n == S_MOVE_UP && state != S_MOVE_UP) begin
                last_dir <= DIR_UP;
            end else if (state_n == S_MOVE_DOWN && state != S_MOVE_DOWN) begin
                last_dir <= DIR_DOWN;
            end
            if (state == S_DOOR_OPEN && state_n == S_DOOR_OPEN) begin
                door_tmr <= door_reload ? '0 : door_tmr + 1'b1;
            end else begin
                door_tmr <= '0;
            end
            if (idle_run) begin
                if (idle_cnt == IW'(IDLE_LOGOUT - 1)) begin
                    logout   <= 1'b1;
                    idle_cnt <= '0;
                end else begin
                    logout   <= 1'b0;
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else begin
                logout   <= 1'b0;
                idle_cnt <= '0;
            end
        end
    end

    always_comb begin
        case (state)
            S_MOVE_UP:   dir_q = DIR_UP;
            S_MOVE_DOWN: dir_q = DIR_DOWN;
            default:     dir_q = DIR_STOP;
        endcase
    end

    assign dir       = dir_q;
    assign door      = (state == S_DOOR_OPEN) ? cur_onehot : '0;
    assign state_dbg = state;

endmodule
